// File: rtl/prv32_alu_pkg.sv
// Shared encodings for the prv32 execute unit.
//   alufn codes : base ALU operations (values match the single-cycle ALU).
//   mdu_op codes: RV32M funct3 values.
//   state_e     : handshake FSM states of prv32_alu_mdu.
package prv32_alu_pkg;

  // Base ALU operations. alufn[0] selects subtraction in the adder, so every
  // code with bit 0 set (sub, pass-b, and, xor, sll, slt, sltu) yields a - b flags.
  localparam logic [3:0] AluAdd   = 4'b0000;
  localparam logic [3:0] AluSub   = 4'b0001;
  localparam logic [3:0] AluPassB = 4'b0011;
  localparam logic [3:0] AluOr    = 4'b0100;
  localparam logic [3:0] AluAnd   = 4'b0101;
  localparam logic [3:0] AluXor   = 4'b0111;
  localparam logic [3:0] AluSrl   = 4'b1000;
  localparam logic [3:0] AluSll   = 4'b1001;
  localparam logic [3:0] AluSra   = 4'b1010;
  localparam logic [3:0] AluSlt   = 4'b1101;
  localparam logic [3:0] AluSltu  = 4'b1111;

  // M-extension operations (funct3).
  localparam logic [2:0] MduMul    = 3'd0;
  localparam logic [2:0] MduMulh   = 3'd1;
  localparam logic [2:0] MduMulhsu = 3'd2;
  localparam logic [2:0] MduMulhu  = 3'd3;
  localparam logic [2:0] MduDiv    = 3'd4;
  localparam logic [2:0] MduDivu   = 3'd5;
  localparam logic [2:0] MduRem    = 3'd6;
  localparam logic [2:0] MduRemu   = 3'd7;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StFix,
    StDone
  } state_e;

endpackage

// File: rtl/prv32_mdu_iter.sv
// Iterative RV32M datapath: radix-2 shift-add multiplier and restoring divider,
// both working on operand magnitudes, one step per cycle for XLEN cycles.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : latch operands/op and initialise the iteration
//   busy       : perform one iteration step this cycle
//   op         : mdu_op (funct3), sampled with start
//   a, b       : operands, sampled with start
//   last       : high during the final iteration step
//   res        : sign-corrected, half-selected result (valid after the last step)
module prv32_mdu_iter import prv32_alu_pkg::*; #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            busy,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            last,
  output logic [XLEN-1:0] res
);

  logic            signed_a, signed_b, neg_a, neg_b, is_div;
  logic [XLEN-1:0] mag_a, mag_b;

  assign signed_a = (op == MduMul) || (op == MduMulh) || (op == MduMulhsu) ||
                    (op == MduDiv) || (op == MduRem);
  assign signed_b = (op == MduMul) || (op == MduMulh) || (op == MduDiv) || (op == MduRem);
  assign neg_a    = signed_a & a[XLEN-1];
  assign neg_b    = signed_b & b[XLEN-1];
  assign mag_a    = neg_a ? -a : a;
  assign mag_b    = neg_b ? -b : b;
  assign is_div   = op[2];

  logic [2:0]        op_q;
  logic              neg_q;
  logic [XLEN-1:0]   opnd_q;   // multiplicand (mul) or divisor (div)
  logic [2*XLEN-1:0] acc_q;    // mul: {partial hi, multiplier}; div: {remainder, quotient}
  logic [SHW-1:0]    cnt_q;

  // Multiply step: conditionally add the multiplicand to the high half, shift right.
  logic [XLEN-1:0]   addend;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  assign addend   = acc_q[0] ? opnd_q : '0;
  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, addend};
  assign mul_next = {mul_sum, acc_q[XLEN-1:1]};

  // Restoring divide step: shift the next dividend bit into the remainder and
  // subtract the divisor if it fits. The remainder stays below the divisor, so
  // XLEN+1 bits cover the shifted value.
  logic [XLEN:0]     shifted, diff;
  logic [2*XLEN-1:0] div_next;
  assign shifted  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
  assign diff     = shifted - {1'b0, opnd_q};
  assign div_next = diff[XLEN] ? {shifted[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                               : {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= '0;
      neg_q  <= 1'b0;
      opnd_q <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
    end else if (start) begin
      op_q   <= op;
      // A remainder takes the dividend's sign; everything else the product of signs.
      neg_q  <= (op == MduRem) ? neg_a : (neg_a ^ neg_b);
      opnd_q <= is_div ? mag_b : mag_a;
      acc_q  <= {{XLEN{1'b0}}, (is_div ? mag_a : mag_b)};
      cnt_q  <= '0;
    end else if (busy) begin
      acc_q  <= op_q[2] ? div_next : mul_next;
      cnt_q  <= cnt_q + SHW'(1);  // wraps to 0 on the final step
    end
  end

  assign last = busy && (cnt_q == SHW'(XLEN - 1));

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem;
  assign prod = neg_q ? -acc_q : acc_q;
  assign quo  = acc_q[XLEN-1:0];
  assign rem  = acc_q[2*XLEN-1:XLEN];

  always_comb begin
    case (op_q)
      MduMul:                       res = prod[XLEN-1:0];
      MduMulh, MduMulhsu, MduMulhu: res = prod[2*XLEN-1:XLEN];
      MduDiv, MduDivu:              res = neg_q ? -quo : quo;
      default:                      res = neg_q ? -rem : rem;
    endcase
  end

endmodule

// File: rtl/prv32_alu_mdu.sv
// EX-stage execute unit: single-cycle base ALU plus iterative RV32M unit,
// behind a valid/ready handshake with registered result and flags.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : request handshake (operands latched on accept)
//   a, b, shamt          : operands and shift amount
//   alufn                : base operation code
//   mdu_sel, mdu_op      : select an M-extension op and its funct3
//   out_valid / out_ready: result handshake
//   r, cf, zf, vf, sf    : registered result and flags, held until consumed
// XLEN must be a power of two, at least 8.
module prv32_alu_mdu import prv32_alu_pkg::*; #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned SHW    = $clog2(XLEN),
  parameter bit          MDU_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [SHW-1:0]  shamt,
  input  logic [3:0]      alufn,
  input  logic            mdu_sel,
  input  logic [2:0]      mdu_op,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] r,
  output logic            cf,
  output logic            zf,
  output logic            vf,
  output logic            sf
);

  state_e          state_q, state_d;
  logic [XLEN-1:0] r_q, r_d;
  logic            cf_q, cf_d, zf_q, zf_d, vf_q, vf_d, sf_q, sf_d;
  logic            accept, mdu_start, mdu_load, mdu_last;
  logic [XLEN-1:0] mdu_res;

  // Back-to-back: a DONE result being consumed frees the unit in the same cycle.
  assign in_ready  = (state_q == StIdle) || ((state_q == StDone) && out_ready);
  assign out_valid = (state_q == StDone);
  assign accept    = in_valid && in_ready;

  // Base ALU adder and flags.
  logic [XLEN-1:0] op_b, sum;
  logic            cf_add, zf_add, vf_add, sf_add;
  assign op_b            = alufn[0] ? ~b : b;
  assign {cf_add, sum}   = {1'b0, a} + {1'b0, op_b} + {{XLEN{1'b0}}, alufn[0]};
  assign zf_add          = (sum == '0);
  assign sf_add          = sum[XLEN-1];
  // Carry into the MSB xor carry out of it.
  assign vf_add          = a[XLEN-1] ^ op_b[XLEN-1] ^ sum[XLEN-1] ^ cf_add;

  logic [XLEN-1:0] base_res;
  always_comb begin
    case (alufn)
      AluAdd, AluSub: base_res = sum;
      AluPassB:       base_res = b;
      AluOr:          base_res = a | b;
      AluAnd:         base_res = a & b;
      AluXor:         base_res = a ^ b;
      AluSrl:         base_res = a >> shamt;
      AluSll:         base_res = a << shamt;
      AluSra:         base_res = $unsigned($signed(a) >>> shamt);
      AluSlt:         base_res = {{(XLEN-1){1'b0}}, (sf_add != vf_add)};
      AluSltu:        base_res = {{(XLEN-1){1'b0}}, ~cf_add};
      default:        base_res = '0;
    endcase
  end

  // Divide corner cases resolved in one cycle without iterating.
  logic            div_zero, div_ovf;
  logic [XLEN-1:0] fast_res;
  assign div_zero = mdu_op[2] && (b == '0);
  assign div_ovf  = mdu_op[2] && !mdu_op[0] && (b == '1) &&
                    (a == {1'b1, {(XLEN-1){1'b0}}});
  assign fast_res = div_zero ? (mdu_op[1] ? a : '1)
                             : (mdu_op[1] ? '0 : a);

  generate
    if (MDU_EN) begin : gen_mdu
      prv32_mdu_iter #(
        .XLEN (XLEN),
        .SHW  (SHW)
      ) u_mdu_iter (
        .clk   (clk),
        .rst_n (rst_n),
        .start (mdu_start),
        .busy  (state_q == StBusy),
        .op    (mdu_op),
        .a     (a),
        .b     (b),
        .last  (mdu_last),
        .res   (mdu_res)
      );
    end else begin : gen_no_mdu
      assign mdu_last = 1'b0;
      assign mdu_res  = '0;
    end
  endgenerate

  always_comb begin
    state_d   = state_q;
    r_d       = r_q;
    cf_d      = cf_q;
    zf_d      = zf_q;
    vf_d      = vf_q;
    sf_d      = sf_q;
    mdu_start = 1'b0;
    mdu_load  = 1'b0;
    case (state_q)
      StIdle, StDone: begin
        if ((state_q == StDone) && out_ready) begin
          state_d = StIdle;
        end
        if (accept) begin
          if (!mdu_sel) begin
            state_d = StDone;
            r_d     = base_res;
            cf_d    = cf_add;
            zf_d    = zf_add;
            vf_d    = vf_add;
            sf_d    = sf_add;
          end else if (!MDU_EN) begin
            state_d  = StDone;
            r_d      = '0;
            mdu_load = 1'b1;
          end else if (div_zero || div_ovf) begin
            state_d  = StDone;
            r_d      = fast_res;
            mdu_load = 1'b1;
          end else begin
            state_d   = StBusy;
            mdu_start = 1'b1;
          end
        end
      end
      StBusy: begin
        if (mdu_last) begin
          state_d = StFix;
        end
      end
      StFix: begin
        state_d  = StDone;
        r_d      = mdu_res;
        mdu_load = 1'b1;
      end
      default: state_d = StIdle;
    endcase
    if (mdu_load) begin
      cf_d = 1'b0;
      vf_d = 1'b0;
      zf_d = (r_d == '0);
      sf_d = r_d[XLEN-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      r_q     <= '0;
      cf_q    <= 1'b0;
      zf_q    <= 1'b0;
      vf_q    <= 1'b0;
      sf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      cf_q    <= cf_d;
      zf_q    <= zf_d;
      vf_q    <= vf_d;
      sf_q    <= sf_d;
    end
  end

  assign r  = r_q;
  assign cf = cf_q;
  assign zf = zf_q;
  assign vf = vf_q;
  assign sf = sf_q;

endmodule

// File: tb/tb_prv32_alu_mdu.sv
// Bench for prv32_alu_mdu: vector table of base and M ops with hand-computed
// results, flags and latency, plus backpressure and reset-mid-op sequences.
module tb_prv32_alu_mdu;

  localparam int unsigned XLEN = 32;
  localparam int unsigned SHW  = 5;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid, in_ready;
  logic [XLEN-1:0] a, b;
  logic [SHW-1:0]  shamt;
  logic [3:0]      alufn;
  logic            mdu_sel;
  logic [2:0]      mdu_op;
  logic            out_valid, out_ready;
  logic [XLEN-1:0] r;
  logic            cf, zf, vf, sf;

  always #5 clk = ~clk;

  prv32_alu_mdu #(
    .XLEN   (XLEN),
    .SHW    (SHW),
    .MDU_EN (1'b1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .shamt     (shamt),
    .alufn     (alufn),
    .mdu_sel   (mdu_sel),
    .mdu_op    (mdu_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .r         (r),
    .cf        (cf),
    .zf        (zf),
    .vf        (vf),
    .sf        (sf)
  );

  typedef struct {
    logic        msel;
    logic [2:0]  mop;
    logic [3:0]  fn;
    logic [31:0] va;
    logic [31:0] vb;
    logic [4:0]  sh;
    logic [31:0] er;
    logic [3:0]  ef;   // {cf, zf, vf, sf}
    int          lat;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic add_vec(input logic msel, input logic [2:0] mop, input logic [3:0] fn,
                         input logic [31:0] va, input logic [31:0] vb, input logic [4:0] sh,
                         input logic [31:0] er, input logic [3:0] ef, input int lat);
    vec_t v;
    v.msel = msel; v.mop = mop; v.fn = fn; v.va = va; v.vb = vb; v.sh = sh;
    v.er = er; v.ef = ef; v.lat = lat;
    vecs.push_back(v);
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int lat;
    @(negedge clk);
    check({tag, " in_ready"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1; mdu_sel = v.msel; mdu_op = v.mop; alufn = v.fn;
    a = v.va; b = v.vb; shamt = v.sh;
    @(posedge clk); #1;
    // Scramble inputs after acceptance: the unit must use the latched copies.
    in_valid = 1'b0; a = $urandom; b = $urandom; shamt = 5'($urandom);
    alufn = 4'($urandom); mdu_op = 3'($urandom); mdu_sel = 1'($urandom);
    wait_valid(lat);
    check({tag, " latency"}, 64'(lat), 64'(v.lat));
    check({tag, " r"}, 64'(r), 64'(v.er));
    check({tag, " flags"}, 64'({cf, zf, vf, sf}), 64'(v.ef));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; mdu_sel = 1'b0; mdu_op = '0;
    alufn = '0; a = '0; b = '0; shamt = '0;
    repeat (2) @(negedge clk);
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset in_ready", 64'(in_ready), 64'd1);
    check("reset r", 64'(r), 64'd0);
    check("reset flags", 64'({cf, zf, vf, sf}), 64'd0);
    rst_n = 1'b1;

    // Base ops: msel, mop, alufn, a, b, shamt, r, {cf,zf,vf,sf}, latency
    add_vec(0, 0, 4'b0001, 32'h5,        32'h7,        0,  32'hFFFFFFFE, 4'b0001, 1);
    add_vec(0, 0, 4'b0000, 32'hFFFFFFFF, 32'h1,        0,  32'h0,        4'b1100, 1);
    add_vec(0, 0, 4'b0000, 32'h7FFFFFFF, 32'h1,        0,  32'h80000000, 4'b0011, 1);
    add_vec(0, 0, 4'b0011, 32'h5,        32'h12345678, 0,  32'h12345678, 4'b0001, 1);
    add_vec(0, 0, 4'b0100, 32'hF0F00000, 32'h00000F0F, 0,  32'hF0F00F0F, 4'b0001, 1);
    add_vec(0, 0, 4'b0101, 32'hFF00FF00, 32'h0F0F0F0F, 0,  32'h0F000F00, 4'b1001, 1);
    add_vec(0, 0, 4'b0111, 32'hAAAAAAAA, 32'hFFFFFFFF, 0,  32'h55555555, 4'b0001, 1);
    add_vec(0, 0, 4'b1000, 32'h80000000, 32'h0,        4,  32'h08000000, 4'b0001, 1);
    add_vec(0, 0, 4'b1001, 32'h00000001, 32'h0,        31, 32'h80000000, 4'b1000, 1);
    add_vec(0, 0, 4'b1010, 32'h80000000, 32'h0,        4,  32'hF8000000, 4'b0001, 1);
    add_vec(0, 0, 4'b1101, 32'hFFFFFFFF, 32'h1,        0,  32'h1,        4'b1001, 1);
    add_vec(0, 0, 4'b1111, 32'hFFFFFFFF, 32'h1,        0,  32'h0,        4'b1001, 1);
    add_vec(0, 0, 4'b0010, 32'h5,        32'h7,        0,  32'h0,        4'b0000, 1);
    // M ops (alufn ignored)
    add_vec(1, 3, 4'b0011, 32'hFFFFFFFF, 32'hFFFFFFFF, 0,  32'hFFFFFFFE, 4'b0001, 34);
    add_vec(1, 0, 4'b0011, 32'hFFFFFFFF, 32'hFFFFFFFF, 0,  32'h00000001, 4'b0000, 34);
    add_vec(1, 4, 4'b0011, 32'hFFFFFFF9, 32'h2,        0,  32'hFFFFFFFD, 4'b0001, 34);
    add_vec(1, 6, 4'b0011, 32'hFFFFFFF9, 32'h2,        0,  32'hFFFFFFFF, 4'b0001, 34);
    add_vec(1, 5, 4'b0011, 32'h1234,     32'h0,        0,  32'hFFFFFFFF, 4'b0001, 1);
    add_vec(1, 7, 4'b0011, 32'h1234,     32'h0,        0,  32'h00001234, 4'b0000, 1);
    add_vec(1, 4, 4'b0011, 32'h80000000, 32'hFFFFFFFF, 0,  32'h80000000, 4'b0001, 1);
    add_vec(1, 6, 4'b0011, 32'h80000000, 32'hFFFFFFFF, 0,  32'h0,        4'b0100, 1);
    add_vec(1, 1, 4'b0011, 32'hFFFFFFFE, 32'h3,        0,  32'hFFFFFFFF, 4'b0001, 34);
    add_vec(1, 2, 4'b0011, 32'hFFFFFFFF, 32'hFFFFFFFF, 0,  32'hFFFFFFFF, 4'b0001, 34);
    add_vec(1, 5, 4'b0011, 32'hFFFFFFFF, 32'h10,       0,  32'h0FFFFFFF, 4'b0000, 34);
    add_vec(1, 7, 4'b0011, 32'hFFFFFFFF, 32'h10,       0,  32'h0000000F, 4'b0000, 34);
    add_vec(1, 6, 4'b0011, 32'h7,        32'hFFFFFFFE, 0,  32'h00000001, 4'b0000, 34);
    add_vec(1, 4, 4'b0011, 32'h7,        32'hFFFFFFFE, 0,  32'hFFFFFFFD, 4'b0001, 34);

    foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Backpressure on a completed DIV, then back-to-back accept of an add.
    @(negedge clk);
    in_valid = 1'b1; mdu_sel = 1'b1; mdu_op = 3'd4; a = 32'hFFFFFFF9; b = 32'h2;
    @(posedge clk); #1;
    in_valid = 1'b0; a = $urandom; b = $urandom;
    wait_valid(lat);
    check("bp latency", 64'(lat), 64'd34);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("bp hold r %0d", i), 64'(r), 64'hFFFFFFFD);
      check($sformatf("bp hold out_valid %0d", i), 64'(out_valid), 64'd1);
      check($sformatf("bp hold in_ready %0d", i), 64'(in_ready), 64'd0);
    end
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; mdu_sel = 1'b0; alufn = 4'b0000;
    a = 32'h2; b = 32'h3;
    #1;
    check("b2b in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0; a = $urandom; b = $urandom;
    check("b2b out_valid", 64'(out_valid), 64'd1);
    check("b2b r", 64'(r), 64'd5);
    check("b2b flags", 64'({cf, zf, vf, sf}), 64'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Reset in the middle of a MUL: result abandoned, unit idle.
    @(negedge clk);
    in_valid = 1'b1; mdu_sel = 1'b1; mdu_op = 3'd0; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    check("mid-op in_ready busy", 64'(in_ready), 64'd0);
    rst_n = 1'b0;
    #1;
    check("rst out_valid", 64'(out_valid), 64'd0);
    check("rst r", 64'(r), 64'd0);
    check("rst in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      vec_t v;
      v.msel = 1'b0; v.mop = 3'd0; v.fn = 4'b0000; v.va = 32'h2; v.vb = 32'h3; v.sh = 5'd0;
      v.er = 32'h5; v.ef = 4'b0000; v.lat = 1;
      run_vec(v, "post-reset add");
    end
    // No stale MUL result may appear afterwards.
    repeat (40) @(posedge clk);
    #1;
    check("no stale out_valid", 64'(out_valid), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
